// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared constants and encodings for the CPU I/O bridge.
// I/O map: 0x30000 UART data, 0x30004..0x30007 cycle-counter snapshot bytes.
package io_bridge_pkg;

    localparam int          TX_DEPTH_DEF = 4;
    localparam logic [17:0] IO_ADDR_UART = 18'h30000;
    localparam logic [17:0] IO_ADDR_CNT  = 18'h30004;
    localparam logic [1:0]  IO_SEL_BITS  = 2'b11;   // cpu_a[17:16] value selecting I/O

    // Registered source of the byte returned to the CPU one cycle later.
    typedef enum logic [1:0] {
        SRC_RAM  = 2'd0,
        SRC_RX   = 2'd1,
        SRC_CNT  = 2'd2,
        SRC_ZERO = 2'd3
    } src_sel_e;

    // Program-stop sequencer.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_STOP  = 2'd2
    } stop_state_e;

endpackage

// File: rtl/io_bridge_fifo.sv
// io_fifo: byte FIFO with wrap-around pointers. Pushes while full are dropped,
// pops while empty are ignored; push and pop in the same cycle both act.
module io_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       i_push,
    input  logic [7:0]                 i_data,
    input  logic                       i_pop,
    output logic [7:0]                 o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk_in) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

endmodule

// File: rtl/io_bridge.sv
// io_bridge: CPU address decode between RAM and a small I/O block
// (UART TX FIFO / RX pop, cycle counter snapshot, program-stop sequencer).
// Optional feature macro: IO_CYCLE_CNT_EN enables the 32-bit cycle counter and
// its snapshot; without it reads of 0x30004..0x30007 return 0x00.
// Every cycle with rdy_in high is a CPU request (read when cpu_wr is 0).
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int TX_DEPTH = TX_DEPTH_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_pop,
    output logic        prog_stop,
    output logic [1:0]  o_dbg_state
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic          w_io;
    logic          w_rd;
    logic          w_wr;
    logic          w_hit_uart;
    logic          w_hit_cnt;
    logic          w_push;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic          w_unused_addr;
    src_sel_e      w_src_next;
    src_sel_e      r_src;
    stop_state_e   r_state;
    stop_state_e   w_state_next;
    logic [7:0]    r_rx_byte;
    logic          r_buf_full;

    // Decode: only cpu_a[17:0] matters; requests are suppressed while rdy_in is low.
    assign w_unused_addr = ^cpu_a[31:18];
    assign w_io       = (cpu_a[17:16] == IO_SEL_BITS);
    assign w_rd       = rdy_in && !cpu_wr;
    assign w_wr       = rdy_in && cpu_wr;
    assign w_hit_uart = (cpu_a[17:0] == IO_ADDR_UART);
    assign w_hit_cnt  = (cpu_a[17:2] == IO_ADDR_CNT[17:2]);

    // RAM passes through combinationally; reset also holds ram_wr low.
    assign ram_a    = cpu_a[16:0];
    assign ram_dout = cpu_dout;
    assign ram_wr   = rst_in && w_wr && !w_io;

    // UART RX pop happens in the request cycle; the byte is latched alongside.
    assign rx_pop = rst_in && w_rd && w_hit_uart && !rx_empty;

    // TX enqueue only in RUN; zero bytes are never queued.
    assign w_push    = w_wr && w_hit_uart && (r_state == ST_RUN) && (cpu_dout != 8'h00);
    assign w_pop     = !w_fifo_empty && !tx_full;
    assign w_push_ok = w_push && !w_fifo_full;
    assign tx_valid  = w_pop;

    assign w_count_next = w_count + CW'(w_push_ok) - CW'(w_pop);

    io_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_push),
        .i_data  (cpu_dout),
        .i_pop   (w_pop),
        .o_data  (tx_data),
        .o_count (w_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Stall flag asserted one entry early so an in-flight CPU write still fits.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_buf_full <= 1'b0;
        else         r_buf_full <= (w_count_next >= CW'(TX_DEPTH - 1));
    end
    assign io_buffer_full = r_buf_full;

    // Next read source; anything not a valid read returns zero.
    always_comb begin
        w_src_next = SRC_ZERO;
        if (w_rd) begin
            if (!w_io)                        w_src_next = SRC_RAM;
            else if (w_hit_uart && !rx_empty) w_src_next = SRC_RX;
`ifdef IO_CYCLE_CNT_EN
            else if (w_hit_cnt)               w_src_next = SRC_CNT;
`endif
        end
    end

    // Read-source register and RX byte capture.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_src     <= SRC_ZERO;
            r_rx_byte <= 8'h00;
        end else begin
            r_src <= w_src_next;
            if (rx_pop) r_rx_byte <= rx_data;
        end
    end

`ifdef IO_CYCLE_CNT_EN
    logic [31:0] r_cnt;
    logic [31:0] r_snap;
    logic [1:0]  r_byte_sel;
    logic [7:0]  w_snap_byte;

    // Free-running cycle counter (frozen by rdy_in) and snapshot on read of 0x30004.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt      <= 32'h0;
            r_snap     <= 32'h0;
            r_byte_sel <= 2'd0;
        end else begin
            if (rdy_in) r_cnt <= r_cnt + 32'd1;
            if (w_rd && (cpu_a[17:0] == IO_ADDR_CNT)) r_snap <= r_cnt;
            if (w_rd) r_byte_sel <= cpu_a[1:0];
        end
    end

    // Byte lane of the snapshot chosen by the registered address bits.
    always_comb begin
        w_snap_byte = 8'h00;
        case (r_byte_sel)
            2'd0: w_snap_byte = r_snap[7:0];
            2'd1: w_snap_byte = r_snap[15:8];
            2'd2: w_snap_byte = r_snap[23:16];
            default: w_snap_byte = r_snap[31:24];
        endcase
    end
`else
    logic [7:0] w_snap_byte;
    assign w_snap_byte = 8'h00;
`endif

    // Return-data mux driven by the registered source select.
    always_comb begin
        cpu_din = 8'h00;
        case (r_src)
            SRC_RAM: cpu_din = ram_din;
            SRC_RX:  cpu_din = r_rx_byte;
            SRC_CNT: cpu_din = w_snap_byte;
            default: cpu_din = 8'h00;
        endcase
    end

    // Stop sequencer state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= ST_RUN;
        else         r_state <= w_state_next;
    end

    // Stop sequencer next state: a write to 0x30004 starts draining; STOP is terminal.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (w_wr && cpu_a[17:0] == IO_ADDR_CNT) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_fifo_empty && !tx_full)           w_state_next = ST_STOP;
            ST_STOP:  w_state_next = ST_STOP;
            default:  w_state_next = ST_RUN;
        endcase
    end

    assign prog_stop   = (r_state == ST_STOP);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: self-checking bench for io_bridge with scoreboard queues for
// read data and UART TX bytes.
module tb_io_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_full;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_pop;
    logic        prog_stop;
    logic [1:0]  dbg_state;

    logic [7:0]  exp_tx_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [31:0] m_cnt;
    logic [31:0] snap;
    int          n_cmp = 0;
    int          n_err = 0;

    io_bridge dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .io_buffer_full(io_buffer_full),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_full(tx_full),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
        .prog_stop(prog_stop), .o_dbg_state(dbg_state)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    // Reference cycle counter: counts edges with rdy_in high since reset.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)     m_cnt <= 32'h0;
        else if (rdy_in) m_cnt <= m_cnt + 32'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // TX monitor: every byte on the UART port must be the next expected one.
    always @(negedge clk_in) begin
        if (rst_in && tx_valid) begin
            if (exp_tx_q.size() == 0) check_eq("tx_unexpected", {24'h0, tx_data}, 32'h100);
            else                      check_eq("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d, input bit enq);
        cpu_a = a; cpu_wr = 1'b1; cpu_dout = d;
        if (enq) exp_tx_q.push_back(d);
        step();
        idle();
    endtask

    task automatic cpu_read(input string tag, input logic [31:0] a, input logic [7:0] exp, input bit exp_pop);
        cpu_a = a; cpu_wr = 1'b0;
        exp_rd_q.push_back(exp);
        #1;
        check_eq({tag, "_pop"}, {31'h0, rx_pop}, {31'h0, exp_pop});
        step();
        idle();
        check_eq(tag, {24'h0, cpu_din}, {24'h0, exp_rd_q.pop_front()});
    endtask

    task automatic wait_tx_drained(input string tag);
        for (int i = 0; i < 30 && exp_tx_q.size() != 0; i++) step();
        step();
        check_eq(tag, exp_tx_q.size(), 0);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; tx_full = 1'b0; rx_empty = 1'b1;
        rx_data = 8'h00; ram_din = 8'hC3;
        idle();
        #12;
        check_eq("rst_cpu_din", {24'h0, cpu_din}, 0);
        check_eq("rst_buf_full", {31'h0, io_buffer_full}, 0);
        check_eq("rst_tx_valid", {31'h0, tx_valid}, 0);
        check_eq("rst_prog_stop", {31'h0, prog_stop}, 0);
        @(negedge clk_in) rst_in = 1'b1;
        step();

        // Zero byte filtered, others emitted in order
        cpu_write(32'h30000, 8'h41, 1);
        cpu_write(32'h30000, 8'h00, 0);
        cpu_write(32'h30000, 8'h42, 1);
        wait_tx_drained("tx_drain_basic");

        // Backpressure: stall after third byte, fourth kept, fifth dropped
        tx_full = 1'b1;
        cpu_write(32'h30000, 8'hA1, 1);
        cpu_write(32'h30000, 8'hA2, 1);
        check_eq("buf_full_after2", {31'h0, io_buffer_full}, 0);
        cpu_write(32'h30000, 8'hA3, 1);
        check_eq("buf_full_after3", {31'h0, io_buffer_full}, 1);
        cpu_write(32'h30000, 8'hA4, 1);
        cpu_write(32'h30000, 8'hA5, 0);
        check_eq("buf_full_after5", {31'h0, io_buffer_full}, 1);
        check_eq("tx_valid_blocked", {31'h0, tx_valid}, 0);
        tx_full = 1'b0;
        wait_tx_drained("tx_drain_full");
        check_eq("buf_full_cleared", {31'h0, io_buffer_full}, 0);

        // UART RX reads
        cpu_read("rx_empty_read", 32'h30000, 8'h00, 0);
        rx_data = 8'h5A; rx_empty = 1'b0;
        cpu_read("rx_data_read", 32'h30000, 8'h5A, 1);
        rx_empty = 1'b1;

        // Unmapped I/O and RAM pass-through
        cpu_read("io_unmapped", 32'h30010, 8'h00, 0);
        cpu_write(32'h30010, 8'h77, 0);
        cpu_a = 32'h1234A; cpu_wr = 1'b1; cpu_dout = 8'h6B;
        #1;
        check_eq("ram_a", {15'h0, ram_a}, 32'h1234A);
        check_eq("ram_wr", {31'h0, ram_wr}, 1);
        check_eq("ram_dout", {24'h0, ram_dout}, 32'h6B);
        idle();
        cpu_read("ram_read", 32'h0ABCD, 8'hC3, 0);

        // rdy_in low suppresses RAM and UART writes
        rdy_in = 1'b0;
        cpu_a = 32'h00100; cpu_wr = 1'b1;
        #1;
        check_eq("ram_wr_not_rdy", {31'h0, ram_wr}, 0);
        cpu_write(32'h30000, 8'h99, 0);
        rdy_in = 1'b1;
        step(); step();

        // Cycle counter snapshot and byte lanes
`ifdef IO_CYCLE_CNT_EN
        snap = m_cnt;
`else
        snap = 32'h0;
`endif
        cpu_read("snap_b0", 32'h30004, snap[7:0], 0);
        step();
        cpu_read("snap_b1", 32'h30005, snap[15:8], 0);
        cpu_read("snap_b2", 32'h30006, snap[23:16], 0);
        cpu_read("snap_b3", 32'h30007, snap[31:24], 0);

        // Reset in the middle of a drain
        tx_full = 1'b1;
        cpu_write(32'h30000, 8'hB1, 1);
        cpu_write(32'h30000, 8'hB2, 1);
        cpu_write(32'h30000, 8'hB3, 1);
        check_eq("buf_full_pre_rst", {31'h0, io_buffer_full}, 1);
        cpu_a = 32'h00200; cpu_wr = 1'b0;
        tx_full = 1'b0;
        @(posedge clk_in);
        #4;
        check_eq("cpu_din_pre_rst", {24'h0, cpu_din}, 32'hC3);
        rst_in = 1'b0;
        exp_tx_q.delete();
        #1;
        check_eq("mid_rst_tx_valid", {31'h0, tx_valid}, 0);
        check_eq("mid_rst_buf_full", {31'h0, io_buffer_full}, 0);
        check_eq("mid_rst_cpu_din", {24'h0, cpu_din}, 0);
        check_eq("mid_rst_state", {30'h0, dbg_state}, 0);
        cpu_wr = 1'b1;
        #1;
        check_eq("mid_rst_ram_wr", {31'h0, ram_wr}, 0);
        idle();
        @(negedge clk_in) rst_in = 1'b1;
        step(); step();
        check_eq("post_rst_tx_valid", {31'h0, tx_valid}, 0);
`ifdef IO_CYCLE_CNT_EN
        snap = m_cnt;
`else
        snap = 32'h0;
`endif
        cpu_read("post_rst_cnt", 32'h30004, snap[7:0], 0);

        // Program stop waits for the FIFO to drain, then holds
        tx_full = 1'b1;
        cpu_write(32'h30000, 8'h11, 1);
        cpu_write(32'h30000, 8'h22, 1);
        cpu_write(32'h30004, 8'h01, 0);
        step(); step();
        check_eq("stop_wait_drain", {31'h0, prog_stop}, 0);
        check_eq("state_drain", {30'h0, dbg_state}, 1);
        cpu_write(32'h30000, 8'h33, 0);
        tx_full = 1'b0;
        for (int i = 0; i < 20 && !prog_stop; i++) step();
        check_eq("prog_stop_set", {31'h0, prog_stop}, 1);
        check_eq("stop_tx_empty", exp_tx_q.size(), 0);
        cpu_write(32'h30000, 8'h44, 0);
        repeat (5) step();
        check_eq("prog_stop_held", {31'h0, prog_stop}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter TX_DEPTH, default 4, UART transmit FIFO depth (power of two, >=2).
REQ-002 clk_in  input  1  system clock; only clock.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  ready; low freezes counter and ignores CPU requests.
REQ-005 cpu_a  input  32  CPU address bus; only bits 17:0 are decoded.
REQ-006 cpu_dout  input  8  CPU write byte.
REQ-007 cpu_wr  input  1  1 = write, 0 = read.
REQ-008 cpu_din  output  8  read byte returned to CPU.
REQ-009 io_buffer_full  output  1  stall indication to CPU.
REQ-010 ram_a  output  17  RAM address; ram_wr output 1; ram_dout output 8; ram_din input 8 (1-cycle read latency).
REQ-011 tx_data  output  8 / tx_valid output 1 / tx_full input 1  UART transmit port.
REQ-012 rx_data  input  8 / rx_empty input 1 / rx_pop output 1  UART receive port.
REQ-013 prog_stop  output  1  program-stop indication.

Function
REQ-014 Decode: cpu_a[17:16]==2'b11 is I/O, otherwise RAM; RAM accesses pass through combinationally (ram_a=cpu_a[16:0], ram_wr=cpu_wr and not I/O).
REQ-015 Read data returns exactly 1 cycle after request; a registered source select (RAM, RX, CNT, ZERO) chooses cpu_din.
REQ-016 Write 0x30000: byte enqueued into TX FIFO; byte 0x00 discarded, not enqueued.
REQ-017 FIFO drains one byte per cycle while not empty and tx_full low: tx_valid=1, tx_data=head.
REQ-018 Simultaneous enqueue and dequeue: count unchanged, both take effect.
REQ-019 io_buffer_full registered, 1 when count >= TX_DEPTH-1 after current update, giving the CPU one cycle slack; enqueue at count==TX_DEPTH is dropped (overflow never corrupts contents).
REQ-020 Read 0x30000: rx_pop pulses 1 cycle if rx_empty low; cpu_din next cycle = rx_data; if rx_empty, returns 0x00, no pop.
REQ-021 Read 0x30004..0x30007: byte (a[1:0]) of 32-bit cycle snapshot; snapshot latched from counter on read of 0x30004 only.
REQ-022 Cycle counter: 32-bit, +1 per cycle with rdy_in high, wraps 0xFFFFFFFF -> 0.
REQ-023 Other I/O addresses: reads return 0x00, writes ignored.
REQ-024 Stop FSM: RUN -> (write 0x30004) DRAIN -> (FIFO empty and tx_full low) STOP; prog_stop=1 only in STOP; STOP is terminal until reset; in DRAIN/STOP further CPU I/O writes ignored.
REQ-025 rdy_in low: counter frozen, CPU requests (including RAM write) suppressed, FIFO drain continues.

Reset
REQ-026 Asserting rst_in at any time immediately clears FIFO (count 0), counter, snapshot, FSM to RUN; outputs cpu_din=0, io_buffer_full=0, tx_valid=0, rx_pop=0, prog_stop=0, ram_wr=0.
REQ-027 Byte in flight on tx at reset is lost; no partial state survives.

Configuration
REQ-028 Macro IO_CYCLE_CNT_EN defined: counter and snapshot present per REQ-021/022.
REQ-029 IO_CYCLE_CNT_EN undefined: no counter/snapshot registers; reads of 0x30004..0x30007 return 0x00.

Structure
REQ-030 Shared package holds I/O address constants (0x30000, 0x30004), I/O decode bits, default TX_DEPTH, source-select encoding.
REQ-031 One sub-module io_fifo (byte FIFO: push, pop, count, full, empty, wrap-around pointers); everything else inline.

Verification
REQ-032 Write 0x41,0x00,0x42 to 0x30000, tx_full=0 -> tx emits 0x41 then 0x42 only.
REQ-033 tx_full held 1, write 4 bytes -> io_buffer_full=1 after 3rd; 4th stored; 5th dropped; release -> exactly 4 bytes out in order.
REQ-034 Read 0x30004 at counter=0x12345678, then 0x30005..7 -> cpu_din 0x78,0x56,0x34,0x12 one cycle after each; without IO_CYCLE_CNT_EN all 0x00.
REQ-035 Bytes queued, write 0x30004 -> prog_stop stays 0 until FIFO drains, then 1 and held.
REQ-036 Read 0x30000 with rx_empty=1 -> 0x00, no rx_pop; with rx_data=0x5A, rx_empty=0 -> rx_pop pulse, cpu_din=0x5A next cycle.
REQ-037 rst_in low mid-drain with 3 queued -> all outputs reset immediately; after release FIFO empty, counter 0.
